neuron_sum_stage: RTL and testbench
===================================

NEURON_SUM_STAGE -- requirements
Module: neuron_sum_stage

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator width in bits, minimum 32.
REQ-002 SHALL have parameter CNT_W, default 8: width of the term-count input.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin one neuron sum; sampled only in IDLE.
REQ-006 count  input  CNT_W  number of weighted terms, unsigned; captured on start.
REQ-007 bias  input  16  signed Q8.8 bias; captured on start.
REQ-008 dest  input  16  destination neuron index; captured on start.
REQ-009 term_valid  input  1  term_x/term_w are valid this cycle.
REQ-010 term_x  input  16  signed Q8.8 activation input.
REQ-011 term_w  input  16  signed Q8.8 weight.
REQ-012 term_ready  output  1  high in ACCUM only; a term is accepted when term_valid and term_ready are both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 out_val  output  16  signed Q8.8 weighted sum for the activation stage's value input.
REQ-015 out_dest  output  16  captured dest for the activation stage's destination input.
REQ-016 out_we  output  1  single-cycle write strobe for the activation stage's write-enable input.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM, ROUND and EMIT.
REQ-018 IDLE: on start, SHALL capture count/bias/dest, load acc = sign-extended bias<<8, then go to ACCUM if count>0, else to ROUND.
REQ-019 ACCUM: on each accepted term, SHALL add the full 32-bit signed product term_x*term_w (Q16.16), sign-extended to ACC_W, to acc and decrement the remaining count.
REQ-020 ACCUM: on acceptance of the last term, SHALL go to ROUND; with term_valid low, SHALL hold state and acc.
REQ-021 ROUND: SHALL compute acc arithmetically shifted right by 8 (truncation toward minus infinity), reduce it to 16 bits per REQ-029/030, register the result into out_val, then go to EMIT.
REQ-022 EMIT: SHALL drive out_we high for exactly one cycle, then go to IDLE.
REQ-023 Latency SHALL be 2 cycles from the clock edge that accepts the last term to the cycle in which out_we is high (for count=0: from the start edge).
REQ-024 out_val and out_dest SHALL hold their values from EMIT until the next ROUND, so the consumer may sample them on or after the out_we cycle.
REQ-025 start while busy SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-026 start in the same cycle as EMIT SHALL be ignored; the next start is accepted no earlier than the cycle after out_we.
REQ-027 term_valid outside ACCUM SHALL be ignored.

Reset
REQ-028 rst SHALL immediately force state IDLE, acc=0, remaining count=0, out_val=0, out_dest=0, out_we=0, term_ready=0 and busy=0; a sum in progress SHALL be abandoned without any out_we pulse.

Configuration
REQ-029 With macro NEURON_SUM_SATURATE_EN defined, ROUND SHALL clamp the shifted sum to the range 0x8000..0x7FFF.
REQ-030 Without NEURON_SUM_SATURATE_EN, ROUND SHALL keep the low 16 bits of the shifted sum (two's-complement wrap).

Structure
REQ-031 Package neuro_pkg SHALL hold the Q8.8 type, the FRAC_BITS=8 constant, the Q8.8 minimum/maximum constants and the FSM state enum.
REQ-032 Saturation SHALL be a separate sub-module neuron_sat16 (ACC_W-bit in, 16-bit out), bypassed when the macro is absent.

Verification
REQ-033 Scenario: count=3, bias=0, three terms x=0x0100, w=0x0200, dest=5 -> one out_we pulse with out_val=0x0600, out_dest=5.
REQ-034 Scenario: count=1, bias=0x0080, x=0xFF00, w=0x0300 -> out_val=0xFD80 (-2.5).
REQ-035 Scenario: count=0, bias=0x0180 -> out_we exactly 2 cycles after the start edge, out_val=0x0180.
REQ-036 Scenario: count=4, bias=0, four terms x=w=0x7FFF -> out_val=0x7FFF with NEURON_SUM_SATURATE_EN defined, 0xFC00 without.
REQ-037 Scenario: rst asserted after 2 of 4 terms, then start count=1, bias=0, x=w=0x0100 -> no pulse for the aborted sum; next pulse has out_val=0x0100.
REQ-038 Scenario: start pulsed during ACCUM plus term_valid gaps of 3 cycles -> result unchanged, exactly one out_we pulse, term_ready high only in ACCUM.

Source files
------------

// File: rtl/neuro_pkg.sv
// Shared Q8.8 types, constants and FSM state encoding for the neuron sum datapath.
package neuro_pkg;

  typedef logic signed [15:0] q88_t;

  localparam int   FRAC_BITS = 8;
  localparam q88_t Q88_MIN   = 16'sh8000;
  localparam q88_t Q88_MAX   = 16'sh7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    EMIT  = 2'd3
  } sumState_t;

endpackage

// File: rtl/neuron_sat16.sv
// Clamps a wide signed value into the Q8.8 range 0x8000..0x7FFF.
module neuron_sat16
  import neuro_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0] din,
  output q88_t                    dout
);

  logic signed [ACC_W-1:0] maxExt_s;
  logic signed [ACC_W-1:0] minExt_s;

  assign maxExt_s = ACC_W'(Q88_MAX);
  assign minExt_s = ACC_W'(Q88_MIN);

  // Select the clamped value or pass the in-range value through.
  always_comb begin
    if (din > maxExt_s) begin
      dout = Q88_MAX;
    end else if (din < minExt_s) begin
      dout = Q88_MIN;
    end else begin
      dout = din[15:0];
    end
  end

endmodule

// File: rtl/neuron_sum_stage.sv
// Weighted-sum stage of a neuron: bias + sum(x*w) in Q16.16, rounded down to Q8.8.
// Define NEURON_SUM_SATURATE_EN to clamp the result instead of wrapping it.
module neuron_sum_stage
  import neuro_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [15:0]      bias,
  input  logic [15:0]      dest,
  input  logic             term_valid,
  input  logic [15:0]      term_x,
  input  logic [15:0]      term_w,
  output logic             term_ready,
  output logic             busy,
  output logic [15:0]      out_val,
  output logic [15:0]      out_dest,
  output logic             out_we
);

  sumState_t               state_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0]        remCnt_r;
  logic [15:0]             dest_r;

  logic signed [31:0]      xExt_s;
  logic signed [31:0]      wExt_s;
  logic signed [31:0]      prod_s;
  logic signed [ACC_W-1:0] prodExt_s;
  logic signed [ACC_W-1:0] biasExt_s;
  q88_t                    rounded_s;

  // Full Q16.16 product; |x*w| never exceeds 2^30 so 32 bits are exact.
  assign xExt_s    = 32'($signed(term_x));
  assign wExt_s    = 32'($signed(term_w));
  assign prod_s    = xExt_s * wExt_s;
  assign prodExt_s = ACC_W'(prod_s);
  assign biasExt_s = ACC_W'($signed(bias)) <<< FRAC_BITS;

`ifdef NEURON_SUM_SATURATE_EN
  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc_r >>> FRAC_BITS;

  neuron_sat16 #(
    .ACC_W(ACC_W)
  ) uSat (
    .din (shifted_s),
    .dout(rounded_s)
  );
`else
  // Wrapping keeps only bits [23:8] of the accumulator, i.e. (acc >>> 8) mod 2^16.
  assign rounded_s = acc_r[FRAC_BITS +: 16];
`endif

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      acc_r      <= {ACC_W{1'b0}};
      remCnt_r   <= {CNT_W{1'b0}};
      dest_r     <= 16'h0000;
      out_val    <= 16'h0000;
      out_dest   <= 16'h0000;
      out_we     <= 1'b0;
      term_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_we <= 1'b0;
          if (start) begin
            remCnt_r <= count;
            dest_r   <= dest;
            acc_r    <= biasExt_s;
            busy     <= 1'b1;
            if (count != {CNT_W{1'b0}}) begin
              state_r    <= ACCUM;
              term_ready <= 1'b1;
            end else begin
              state_r    <= ROUND;
              term_ready <= 1'b0;
            end
          end else begin
            busy       <= 1'b0;
            term_ready <= 1'b0;
          end
        end
        ACCUM: begin
          if (term_valid && term_ready) begin
            acc_r    <= acc_r + prodExt_s;
            remCnt_r <= remCnt_r - CNT_W'(1);
            if (remCnt_r == CNT_W'(1)) begin
              state_r    <= ROUND;
              term_ready <= 1'b0;
            end else begin
              state_r    <= ACCUM;
              term_ready <= 1'b1;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        ROUND: begin
          out_val  <= rounded_s;
          out_dest <= dest_r;
          out_we   <= 1'b1;
          state_r  <= EMIT;
        end
        EMIT: begin
          out_we  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          out_we     <= 1'b0;
          busy       <= 1'b0;
          term_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sum_stage.sv
// Self-checking bench for neuron_sum_stage: directed scenarios plus randomized sums.
module tb_neuron_sum_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  count = 8'd0;
  logic [15:0] bias = 16'h0000;
  logic [15:0] dest = 16'h0000;
  logic        term_valid = 1'b0;
  logic [15:0] term_x = 16'h0000;
  logic [15:0] term_w = 16'h0000;
  logic        term_ready;
  logic        busy;
  logic [15:0] out_val;
  logic [15:0] out_dest;
  logic        out_we;

  int nAsserts = 0;
  int nFails   = 0;

  logic [15:0] xs[16];
  logic [15:0] ws[16];

  neuron_sum_stage #(.ACC_W(40), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .bias      (bias),
    .dest      (dest),
    .term_valid(term_valid),
    .term_x    (term_x),
    .term_w    (term_w),
    .term_ready(term_ready),
    .busy      (busy),
    .out_val   (out_val),
    .out_dest  (out_dest),
    .out_we    (out_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, floor-divide by 256, then clamp or wrap.
  function automatic logic [15:0] refSum(input int n, input logic [15:0] b);
    longint s;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < n; i++)
      s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    s = s >>> 8;
`ifdef NEURON_SUM_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Drives one complete sum and checks handshake, latency, single pulse and result.
  task automatic runSum(input string tag, input int n, input logic [15:0] b, input logic [15:0] d,
                        input logic [15:0] expVal, input int gapMode, input bit poke);
    int k = 0;
    int lastEdge = 0;
    int pulses = 0;
    int gapCnt = 0;
    check({tag, " idle before start"}, {31'd0, busy}, 32'd0);
    start = 1'b1; count = n[7:0]; bias = b; dest = d; term_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; count = 8'($urandom); bias = 16'($urandom); dest = 16'($urandom);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      check({tag, " term_ready"}, {31'd0, term_ready}, {31'd0, (k < n)});
      check({tag, " busy"}, {31'd0, busy}, {31'd0, !(k == n && cyc >= lastEdge + 3)});
      if (out_we === 1'b1) begin
        pulses++;
        check({tag, " latency"}, cyc, lastEdge + 2);
        check({tag, " out_val"}, {16'd0, out_val}, {16'd0, expVal});
        check({tag, " out_dest"}, {16'd0, out_dest}, {16'd0, d});
      end
      if (k == n && cyc >= lastEdge + 4) break;
      start = poke && (k == 1) && (n >= 3);
      count = 8'($urandom_range(1, 5));
      if (k < n && gapCnt == 0) begin
        term_valid = 1'b1; term_x = xs[k]; term_w = ws[k];
        k++;
        lastEdge = cyc;
        gapCnt = (gapMode < 0) ? int'($urandom_range(0, 2)) : gapMode;
      end else begin
        term_valid = (k >= n) ? 1'($urandom) : 1'b0;
        term_x = 16'($urandom); term_w = 16'($urandom);
        if (gapCnt > 0) gapCnt--;
      end
      @(negedge clk);
    end
    check({tag, " pulse count"}, pulses, 32'd1);
    check({tag, " result held"}, {16'd0, out_val}, {16'd0, expVal});
    start = 1'b0; term_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset term_ready", {31'd0, term_ready}, 32'd0);
    check("reset out_we", {31'd0, out_we}, 32'd0);
    check("reset out_val", {16'd0, out_val}, 32'd0);
    check("reset out_dest", {16'd0, out_dest}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin xs[i] = 16'h0100; ws[i] = 16'h0200; end
    runSum("three terms", 3, 16'h0000, 16'd5, 16'h0600, 0, 1'b0);

    xs[0] = 16'hFF00; ws[0] = 16'h0300;
    runSum("negative result", 1, 16'h0080, 16'd9, 16'hFD80, 0, 1'b0);

    runSum("zero count", 0, 16'h0180, 16'd3, 16'h0180, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin xs[i] = 16'h7FFF; ws[i] = 16'h7FFF; end
`ifdef NEURON_SUM_SATURATE_EN
    runSum("overflow", 4, 16'h0000, 16'd11, 16'h7FFF, 0, 1'b0);
`else
    runSum("overflow", 4, 16'h0000, 16'd11, 16'hFC00, 0, 1'b0);
`endif

    // Abort a sum after two of four terms
    xs[0] = 16'h0100; ws[0] = 16'h0100; xs[1] = 16'h0200; ws[1] = 16'h0100;
    start = 1'b1; count = 8'd4; bias = 16'h0000; dest = 16'd21;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      term_valid = 1'b1; term_x = xs[i]; term_w = ws[i];
      @(negedge clk);
    end
    term_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort term_ready", {31'd0, term_ready}, 32'd0);
    check("abort out_val", {16'd0, out_val}, 32'd0);
    check("abort out_dest", {16'd0, out_dest}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      term_valid = 1'($urandom); term_x = 16'($urandom); term_w = 16'($urandom);
      @(negedge clk);
      check("abort no pulse", {31'd0, out_we}, 32'd0);
    end
    term_valid = 1'b0;
    xs[0] = 16'h0100; ws[0] = 16'h0100;
    runSum("after abort", 1, 16'h0000, 16'd7, 16'h0100, 0, 1'b0);

    // Gaps of three cycles and a stray start during accumulation
    xs[0] = 16'h0100; ws[0] = 16'h0100;
    xs[1] = 16'h0100; ws[1] = 16'h0200;
    xs[2] = 16'h0100; ws[2] = 16'hFF00;
    runSum("gaps and stray start", 3, 16'h0040, 16'd42, 16'h0240, 3, 1'b1);

    // Randomized sums against the reference model
    for (int t = 0; t < 8; t++) begin
      int n;
      logic [15:0] b;
      n = int'($urandom_range(0, 10));
      b = 16'($urandom);
      for (int i = 0; i < n; i++) begin xs[i] = 16'($urandom); ws[i] = 16'($urandom); end
      runSum("random", n, b, 16'($urandom), refSum(n, b), -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
